reg_wb_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single write port of the 32-bit register

---
 rtl/reg_wb_arbiter_if.sv | 33 +++
 rtl/reg_wb_arbiter.sv | 106 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_arbiter_if
//  Purpose  : Writeback request bundle and register-bank write port for the
//             shared write-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_wb_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic                 stall;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic                 rf_load;
    logic [AW-1:0]        rf_addr;
    logic [DW-1:0]        rf_data;
    logic [2:0]           ptr;

    modport master (
        output stall, req, req_addr, req_data,
        input  ack, rf_load, rf_addr, rf_data, ptr
    );

    modport slave (
        input  stall, req, req_addr, req_data,
        output ack, rf_load, rf_addr, rf_data, ptr
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_arbiter
//  Purpose  : Round-robin arbiter for the single register-bank write port,
//             combinational ack, registered write stage, x0 writes discarded.
//  Revision : 1.0  initial release
// ============================================================================
module reg_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    reg_wb_arbiter_if.slave   bus
);

    logic [2:0]      ptr_q, ptr_d;
    logic            rf_load_q, rf_load_d;
    logic [AW-1:0]   rf_addr_q, rf_addr_d;
    logic [DW-1:0]   rf_data_q, rf_data_d;

    logic [2:0]      scan_idx;
    logic [2:0]      win_idx;
    logic            win_valid;
    logic            scan_hit;
    logic            xfer;
    logic [NREQ-1:0] ack_w;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // Walk the requesters starting at ptr, wrapping at NREQ-1; first hit wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = ptr_q;
        scan_hit  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan_hit = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (scan_idx == 3'(i)) begin
                    scan_hit = bus.req[i];
                end
            end
            if (!win_valid && scan_hit) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == 3'(NREQ-1)) ? 3'd0 : scan_idx + 3'd1;
        end
    end

    // rst is active-low, so ack is forced low for as long as reset is held.
    assign xfer = win_valid & ~bus.stall & rst;

    always_comb begin
        ack_w    = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                ack_w[i] = xfer;
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        rf_load_d = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (xfer) begin
            ptr_d = (win_idx == 3'(NREQ-1)) ? 3'd0 : win_idx + 3'd1;
            // Writes to x0 complete the handshake but never reach the bank.
            if (sel_addr != '0) begin
                rf_load_d = 1'b1;
                rf_addr_d = sel_addr;
                rf_data_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= 3'd0;
            rf_load_q <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rf_load_q <= rf_load_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign bus.ack     = ack_w;
    assign bus.rf_load = rf_load_q;
    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_data = rf_data_q;
    assign bus.ptr     = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_wb_arbiter
//  Purpose  : Self-checking bench for reg_wb_arbiter: vector table, directed
//             reset sequences and a randomized run against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_wb_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h3333_0002;
    localparam logic [31:0] D3 = 32'h4444_0003;

    localparam logic [19:0]  A_STD = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0]  A_S2  = {5'd4, 5'd7, 5'd2, 5'd1};
    localparam logic [19:0]  A_X0  = {5'd4, 5'd3, 5'd0, 5'd1};
    localparam logic [127:0] D_STD = {D3, D2, D1, D0};
    localparam logic [127:0] D_S2  = {D3, 32'hDEAD_BEEF, D1, D0};
    localparam logic [127:0] D_X0  = {D3, D2, 32'hFFFF_FFFF, D0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    reg_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]   req;
        logic         stall;
        logic [19:0]  addr;
        logic [127:0] data;
        logic [3:0]   exp_ack;
        logic         exp_load;
        logic [4:0]   exp_addr;
        logic [31:0]  exp_data;
        logic [2:0]   exp_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] rq, input logic st, input logic [19:0] a,
                       input logic [127:0] d, input logic [3:0] eack, input logic eld,
                       input logic [4:0] ea, input logic [31:0] ed, input logic [2:0] ep);
        vec_t v;
        v.req = rq; v.stall = st; v.addr = a; v.data = d;
        v.exp_ack = eack; v.exp_load = eld; v.exp_addr = ea; v.exp_data = ed; v.exp_ptr = ep;
        vecs.push_back(v);
    endtask

    task automatic chk_regs(input string tag, input logic eld, input logic [4:0] ea,
                            input logic [31:0] ed, input logic [2:0] ep);
        chk({tag, ".rf_load"}, 32'(bus.rf_load), 32'(eld));
        chk({tag, ".rf_addr"}, 32'(bus.rf_addr), 32'(ea));
        chk({tag, ".rf_data"}, bus.rf_data, ed);
        chk({tag, ".ptr"},     32'(bus.ptr),     32'(ep));
    endtask

    // Reference model state for the randomized run.
    int           m_ptr;
    logic         m_load;
    logic [4:0]   m_addr;
    logic [31:0]  m_data;
    logic         pend  [NREQ];
    logic [4:0]   paddr [NREQ];
    logic [31:0]  pdata [NREQ];
    int           waits [NREQ];

    initial begin
        bus.stall    = 1'b0;
        bus.req      = 4'b1111;
        bus.req_addr = A_STD;
        bus.req_data = D_STD;

        // Reset held with all sources requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ack", 32'(bus.ack), 32'h0);
        chk_regs("reset", 1'b0, 5'd0, 32'h0, 3'd0);
        rst = 1'b1;
        #1;
        chk("release.ack", 32'(bus.ack), 32'b0001);

        add(4'b0100, 1'b0, A_S2,  D_S2,  4'b0100, 1'b1, 5'd7, 32'hDEAD_BEEF, 3'd3);
        add(4'b1111, 1'b0, A_STD, D_STD, 4'b1000, 1'b1, 5'd4, D3, 3'd0);
        add(4'b1111, 1'b0, A_STD, D_STD, 4'b0001, 1'b1, 5'd1, D0, 3'd1);
        add(4'b1111, 1'b0, A_STD, D_STD, 4'b0010, 1'b1, 5'd2, D1, 3'd2);
        add(4'b1111, 1'b0, A_STD, D_STD, 4'b0100, 1'b1, 5'd3, D2, 3'd3);
        add(4'b1111, 1'b0, A_STD, D_STD, 4'b1000, 1'b1, 5'd4, D3, 3'd0);
        add(4'b1111, 1'b0, A_STD, D_STD, 4'b0001, 1'b1, 5'd1, D0, 3'd1);
        add(4'b0010, 1'b0, A_X0,  D_X0,  4'b0010, 1'b0, 5'd1, D0, 3'd2);
        add(4'b0001, 1'b0, A_STD, D_STD, 4'b0001, 1'b1, 5'd1, D0, 3'd1);
        add(4'b0011, 1'b1, A_STD, D_STD, 4'b0000, 1'b0, 5'd1, D0, 3'd1);
        add(4'b0011, 1'b1, A_STD, D_STD, 4'b0000, 1'b0, 5'd1, D0, 3'd1);
        add(4'b0011, 1'b1, A_STD, D_STD, 4'b0000, 1'b0, 5'd1, D0, 3'd1);
        add(4'b0011, 1'b0, A_STD, D_STD, 4'b0010, 1'b1, 5'd2, D1, 3'd2);
        add(4'b0011, 1'b0, A_STD, D_STD, 4'b0001, 1'b1, 5'd1, D0, 3'd1);
        add(4'b0000, 1'b0, A_STD, D_STD, 4'b0000, 1'b0, 5'd1, D0, 3'd1);

        foreach (vecs[n]) begin
            bus.req      = vecs[n].req;
            bus.stall    = vecs[n].stall;
            bus.req_addr = vecs[n].addr;
            bus.req_data = vecs[n].data;
            #3;
            chk($sformatf("vec%0d.ack", n), 32'(bus.ack), 32'(vecs[n].exp_ack));
            @(posedge clk);
            #1;
            chk_regs($sformatf("vec%0d", n), vecs[n].exp_load, vecs[n].exp_addr,
                     vecs[n].exp_data, vecs[n].exp_ptr);
        end

        // Async reset: one write in flight on the bank, the next one acked.
        bus.req = 4'b0100; bus.req_addr = A_S2; bus.req_data = D_S2;
        #3;
        chk("arst.ack0", 32'(bus.ack), 32'b0100);
        @(posedge clk);
        #1;
        chk_regs("arst.pre", 1'b1, 5'd7, 32'hDEAD_BEEF, 3'd3);
        bus.req = 4'b1000;
        #1;
        chk("arst.ack1", 32'(bus.ack), 32'b1000);
        rst = 1'b0;
        #1;
        chk("arst.ack_low", 32'(bus.ack), 32'h0);
        chk_regs("arst.now", 1'b0, 5'd0, 32'h0, 3'd0);
        @(posedge clk);
        #1;
        chk_regs("arst.edge", 1'b0, 5'd0, 32'h0, 3'd0);
        bus.req = 4'b0000;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized run against the reference model.
        m_ptr = 0; m_load = 1'b0; m_addr = 5'd0; m_data = 32'h0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; paddr[i] = 5'd0; pdata[i] = 32'h0; waits[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int w;
            logic [3:0] eack;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                    pdata[i] = $urandom;
                end
                bus.req[i]             = pend[i];
                bus.req_addr[i*AW +: AW] = paddr[i];
                bus.req_data[i*DW +: DW] = pdata[i];
            end
            bus.stall = ($urandom_range(0, 3) == 0);

            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && pend[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            eack = (!bus.stall && w >= 0) ? 4'(1 << w) : 4'b0000;
            #3;
            chk("rand.ack", 32'(bus.ack), 32'(eack));
            @(posedge clk);
            #1;
            m_load = 1'b0;
            if (eack != 4'b0000) begin
                chk("rand.fair", 32'(waits[w] <= NREQ - 1), 32'h1);
                for (int j = 0; j < NREQ; j++) begin
                    if (j != w && pend[j]) waits[j]++;
                end
                waits[w] = 0;
                m_ptr    = (w + 1) % NREQ;
                if (paddr[w] != 5'd0) begin
                    m_load = 1'b1;
                    m_addr = paddr[w];
                    m_data = pdata[w];
                end
                pend[w] = 1'b0;
            end
            chk_regs("rand", m_load, m_addr, m_data, 3'(m_ptr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
